// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes RV32I OP, OP-IMM, LUI and AUIPC into a 4-bit
// ALU operation plus operands, delivered through a 2-entry skid buffer.
module alu_issue_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [31:0]     in_pc,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_aluop,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   localparam int unsigned AW = 4;
   localparam int unsigned RW = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [AW-1:0] OP_PASS_B = 4'b1111;

   typedef struct packed {
      logic [AW-1:0]   aluop;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [RW-1:0]   rd;
      logic            illegal;
   } issue_t;

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic            is_shift;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt_i;
   logic [XLEN-1:0] shamt_r;
   issue_t          dec;

   issue_t out_q,  out_n;
   issue_t skid_q, skid_n;
   logic   out_valid_q, out_valid_n;
   logic   skid_valid_q, skid_valid_n;
   logic   in_ready_q, in_ready_n;
   logic   in_fire;
   logic   out_free;

   assign opcode   = in_inst[6:0];
   assign f3       = in_inst[14:12];
   assign f7       = in_inst[31:25];
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
   assign imm_i    = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_u    = {in_inst[31:12], 12'b0};
   assign shamt_i  = {27'b0, in_inst[24:20]};
   assign shamt_r  = {27'b0, in_rs2_val[4:0]};

   // Combinational decode of the incoming instruction; illegal encodings carry zero operands.
   always_comb begin
      dec         = '0;
      dec.rd      = in_inst[11:7];
      dec.illegal = 1'b1;
      unique case (opcode)
         OPC_OP: begin
            if ((f7 == F7_ZERO) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
               dec.illegal = 1'b0;
               dec.aluop   = {f7[5], f3};
               dec.a       = in_rs1_val;
               dec.b       = is_shift ? shamt_r : in_rs2_val;
            end
         end
         OPC_OP_IMM: begin
            if (f3 == 3'b001) begin
               if (f7 == F7_ZERO) begin
                  dec.illegal = 1'b0;
                  dec.aluop   = {1'b0, f3};
                  dec.a       = in_rs1_val;
                  dec.b       = shamt_i;
               end
            end else if (f3 == 3'b101) begin
               if ((f7 == F7_ZERO) || (f7 == F7_ALT)) begin
                  dec.illegal = 1'b0;
                  dec.aluop   = {in_inst[30], f3};
                  dec.a       = in_rs1_val;
                  dec.b       = shamt_i;
               end
            end else begin
               dec.illegal = 1'b0;
               dec.aluop   = {1'b0, f3};
               dec.a       = in_rs1_val;
               dec.b       = imm_i;
            end
         end
         OPC_LUI: begin
            dec.illegal = 1'b0;
            dec.aluop   = OP_PASS_B;
            dec.b       = imm_u;
         end
         OPC_AUIPC: begin
            dec.illegal = 1'b0;
            dec.a       = in_pc;
            dec.b       = imm_u;
         end
         default: ;
      endcase
   end

   assign in_fire  = in_valid && in_ready_q;
   assign out_free = !out_valid_q || out_ready;

   // Skid-buffer next state: fill output when free, park in skid when stalled.
   always_comb begin
      out_n        = out_q;
      out_valid_n  = out_valid_q;
      skid_n       = skid_q;
      skid_valid_n = skid_valid_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_n        = skid_q;
            out_valid_n  = 1'b1;
            skid_valid_n = 1'b0;
         end else if (in_fire) begin
            out_n       = dec;
            out_valid_n = 1'b1;
         end else begin
            out_valid_n = 1'b0;
         end
      end else if (in_fire) begin
         skid_n       = dec;
         skid_valid_n = 1'b1;
      end
      in_ready_n = !skid_valid_n;
   end

   // State registers with synchronous reset; reset drops any in-flight entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_n;
         skid_q       <= skid_n;
         out_valid_q  <= out_valid_n;
         skid_valid_q <= skid_valid_n;
         in_ready_q   <= in_ready_n;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_aluop   = out_q.aluop;
   assign out_a       = out_q.a;
   assign out_b       = out_q.b;
   assign out_rd      = out_q.rd;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_val;
   logic [31:0] in_rs2_val;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_aluop;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int errors = 0;
   int checks = 0;
   bit armed  = 1'b0;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t       q[$];
   logic [4:0] dut_rds[$];

   alu_issue_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_aluop(out_aluop), .out_a(out_a), .out_b(out_b),
      .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   // Reference decode written from the instruction-set rules.
   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] r1, input logic [31:0] r2);
      exp_t       e;
      logic [6:0] opc;
      logic [2:0] fn3;
      logic [6:0] fn7;
      bit         alt;
      opc = inst[6:0];
      fn3 = inst[14:12];
      fn7 = inst[31:25];
      alt = (fn7 == 7'h20);
      e = '0;
      e.rd = inst[11:7];
      e.ill = 1'b1;
      if (opc == 7'h33) begin
         if (fn7 == 7'h00 || (alt && (fn3 == 3'd0 || fn3 == 3'd5))) begin
            e.ill = 1'b0;
            e.op  = alt ? 4'(8 + int'(fn3)) : 4'(fn3);
            e.a   = r1;
            e.b   = (fn3 == 3'd1 || fn3 == 3'd5) ? (r2 % 32) : r2;
         end
      end else if (opc == 7'h13) begin
         if (fn3 == 3'd1) begin
            if (fn7 == 7'h00) begin
               e.ill = 1'b0; e.op = 4'd1; e.a = r1; e.b = 32'(inst[24:20]);
            end
         end else if (fn3 == 3'd5) begin
            if (fn7 == 7'h00 || alt) begin
               e.ill = 1'b0; e.op = alt ? 4'd13 : 4'd5; e.a = r1; e.b = 32'(inst[24:20]);
            end
         end else begin
            e.ill = 1'b0; e.op = 4'(fn3); e.a = r1;
            e.b = 32'($signed(inst[31:20]));
         end
      end else if (opc == 7'h37) begin
         e.ill = 1'b0; e.op = 4'd15; e.b = inst & 32'hFFFF_F000;
      end else if (opc == 7'h17) begin
         e.ill = 1'b0; e.op = 4'd0; e.a = pc; e.b = inst & 32'hFFFF_F000;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic ill);
      chk({name, ".valid"}, 32'(out_valid), 32'd1);
      chk({name, ".aluop"}, 32'(out_aluop), 32'(op));
      chk({name, ".a"}, out_a, a);
      chk({name, ".b"}, out_b, b);
      chk({name, ".rd"}, 32'(out_rd), 32'(rd));
      chk({name, ".illegal"}, 32'(out_illegal), 32'(ill));
   endtask

   // Model update at the active edge, from bench-driven inputs only.
   always @(posedge clk) begin
      bit fire_in;
      bit fire_out;
      if (rst) begin
         q.delete();
      end else begin
         fire_out = (q.size() > 0) && out_ready;
         fire_in  = in_valid && (q.size() < 2);
         if (fire_out) void'(q.pop_front());
         if (fire_in) q.push_back(model(in_inst, in_pc, in_rs1_val, in_rs2_val));
      end
   end

   // Per-cycle comparison of DUT outputs against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (armed) begin
         chk("cyc.out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("cyc.in_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() > 0 && out_valid) begin
            chk("cyc.aluop", 32'(out_aluop), 32'(q[0].op));
            chk("cyc.a", out_a, q[0].a);
            chk("cyc.b", out_b, q[0].b);
            chk("cyc.rd", 32'(out_rd), 32'(q[0].rd));
            chk("cyc.illegal", 32'(out_illegal), 32'(q[0].ill));
         end
         if (out_valid && out_ready && !rst) dut_rds.push_back(out_rd);
      end
   end

   task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
      int   n;
      logic acc;
      in_inst = inst; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2;
      in_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end
      #1;
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: inst %h not accepted within %0d cycles", inst, n);
      end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  f7;
      int          k;
      int          j;
      w = $urandom;
      k = $urandom_range(0, 9);
      j = $urandom_range(0, 3);
      f7 = (j < 2) ? 7'h00 : (j == 2) ? 7'h20 : 7'($urandom);
      if (k < 3)       w[6:0] = 7'h33;
      else if (k < 6)  w[6:0] = 7'h13;
      else if (k == 6) w[6:0] = 7'h37;
      else if (k == 7) w[6:0] = 7'h17;
      if (k < 6) w[31:25] = f7;
      return w;
   endfunction

   initial begin
      exp_t e;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_inst = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.aluop", 32'(out_aluop), 32'd0);
      chk("reset.a", out_a, 32'd0);
      chk("reset.b", out_b, 32'd0);
      chk("reset.rd", 32'(out_rd), 32'd0);
      chk("reset.illegal", 32'(out_illegal), 32'd0);
      armed = 1'b1;

      e = model(32'h4020_8033, 32'h0, 32'd10, 32'd3);
      chk("model.sub.op", 32'(e.op), 32'd8);
      chk("model.sub.b", e.b, 32'd3);
      e = model(32'h4043_5293, 32'h0, 32'h8000_0000, 32'h0);
      chk("model.srai.op", 32'(e.op), 32'd13);

      @(posedge clk); #1;
      send(32'h4020_8033, 32'h0, 32'd10, 32'd3);
      @(negedge clk); chk_out("sub", 4'b1000, 32'd10, 32'd3, 5'd0, 1'b0);
      send(32'h4043_5293, 32'h0, 32'h8000_0000, 32'h55);
      @(negedge clk); chk_out("srai", 4'b1101, 32'h8000_0000, 32'd4, 5'd5, 1'b0);
      send(32'h4000_0093, 32'h0, 32'd7, 32'h99);
      @(negedge clk); chk_out("addi30", 4'b0000, 32'd7, 32'h400, 5'd1, 1'b0);
      send(32'h1234_50B7, 32'h0, 32'h77, 32'h88);
      @(negedge clk); chk_out("lui", 4'b1111, 32'd0, 32'h1234_5000, 5'd1, 1'b0);
      send(32'h1234_5097, 32'h100, 32'h77, 32'h88);
      @(negedge clk); chk_out("auipc", 4'b0000, 32'h100, 32'h1234_5000, 5'd1, 1'b0);
      send(32'h0000_006F, 32'h200, 32'h33, 32'h44);
      @(negedge clk); chk_out("jal", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1);
      send(32'h4020_9093, 32'h0, 32'h33, 32'h44);
      @(negedge clk); chk_out("slli_bad", 4'b0000, 32'd0, 32'd0, 5'd1, 1'b1);

      // Backpressure: two accepted, third held, then in-order drain.
      @(posedge clk); #1;
      out_ready = 1'b0;
      dut_rds.delete();
      send(32'h0020_80B3, 32'h0, 32'd1, 32'd2);
      send(32'h0020_8133, 32'h0, 32'd3, 32'd4);
      @(negedge clk);
      chk("bp.in_ready_low", 32'(in_ready), 32'd0);
      chk("bp.head_rd", 32'(out_rd), 32'd1);
      in_inst = 32'h0020_81B3; in_pc = '0; in_rs1_val = 32'd5; in_rs2_val = 32'd6;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp.stall_rd", 32'(out_rd), 32'd1);
         chk("bp.stall_a", out_a, 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h0020_81B3, 32'h0, 32'd5, 32'd6);
      repeat (4) @(posedge clk);
      #1;
      chk("bp.count", 32'(dut_rds.size()), 32'd3);
      if (dut_rds.size() == 3) begin
         chk("bp.order0", 32'(dut_rds[0]), 32'd1);
         chk("bp.order1", 32'(dut_rds[1]), 32'd2);
         chk("bp.order2", 32'(dut_rds[2]), 32'd3);
      end

      // Reset with both entries full and output stalled.
      out_ready = 1'b0;
      send(32'h0020_8233, 32'h0, 32'd1, 32'd2);
      send(32'h0020_82B3, 32'h0, 32'd1, 32'd2);
      in_inst = 32'h0020_8333; in_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rstmid.out_valid", 32'(out_valid), 32'd0);
      chk("rstmid.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      dut_rds.delete();
      out_ready = 1'b1;
      send(32'h0020_84B3, 32'h0, 32'd1, 32'd2);
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid.count", 32'(dut_rds.size()), 32'd1);
      if (dut_rds.size() == 1) chk("rstmid.rd", 32'(dut_rds[0]), 32'd9);

      // Randomized traffic with random backpressure and occasional reset.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst        = ($urandom_range(0, 299) == 0);
         in_valid   = $urandom_range(0, 1) == 1;
         out_ready  = $urandom_range(0, 9) < 6;
         in_inst    = rand_inst();
         in_pc      = $urandom;
         in_rs1_val = $urandom;
         in_rs2_val = $urandom;
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
